uart0_tx_serializer: RTL and testbench

//  Drains the UART0 transmit FIFO and serialises each byte onto the TXD pin as an asynchronous frame.

---
 rtl/uart0_tx_serializer_pkg.sv | 23 ++
 rtl/uart0_tx_serializer_baud_tick.sv | 39 +++
 rtl/uart0_tx_serializer.sv | 179 +++++++++++++++++
 tb/tb_uart0_tx_serializer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart0_tx_serializer_pkg.sv
// Shared definitions for the UART0 transmit serializer.
//   tx_state_e       : FSM state encoding (3 bits)
//   UartBaudDefault  : default line rate
//   baud_div()       : clocks per bit, rounded to nearest
package uart0_tx_serializer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StLat   = 3'd2,
    StStart = 3'd3,
    StData  = 3'd4,
    StPar   = 3'd5,
    StStop  = 3'd6
  } tx_state_e;

  localparam int unsigned UartBaudDefault = 115200;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart0_tx_serializer_baud_tick.sv
// Loadable bit-period down-counter.
//   clk  : system clock
//   rst  : synchronous reset, active high (count -> 0)
//   load : preset the count to Div-1 (wins over en)
//   en   : count down; on reaching zero, reload Div-1
//   tick : high while the count is zero (last clock of the bit period)
module uart0_tx_serializer_baud_tick #(
  parameter int unsigned Div  = 4,
  parameter int unsigned CntW = $clog2(Div)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(Div - 1);
    end else if (en) begin
      cnt_d = tick ? CntW'(Div - 1) : cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart0_tx_serializer.sv
// UART0 transmit serializer: pops bytes from the TX FIFO (normal-mode read, data one cycle after
// the read strobe) and sends each as start + 8 data (LSB first) + optional parity + 1/2 stop bits.
//   clk           : system clock
//   rst           : synchronous reset, active high
//   ena           : allow new frames; a frame in flight always completes
//   tx_fifo_empty : FIFO empty flag (looked at only in idle)
//   tx_fifo_ren   : one-cycle FIFO read strobe
//   tx_fifo_rdata : FIFO read data, valid the cycle after tx_fifo_ren
//   txd           : registered serial line, idle high
//   tx_busy       : high from the read strobe to the end of the last stop bit
//   tx_done       : one-cycle pulse after each completed frame
//   frame_cnt     : completed frames since reset, wraps at 16 bits
module uart0_tx_serializer
  import uart0_tx_serializer_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = UartBaudDefault,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        tx_fifo_empty,
  output logic        tx_fifo_ren,
  input  logic [7:0]  tx_fifo_rdata,
  output logic        txd,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned BaudDiv = baud_div(CLK_HZ, BAUD);

  tx_state_e   state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic        txd_q, txd_d;
  logic        ren_q, ren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic baud_load, baud_en, baud_tick;
  logic last_stop;

  uart0_tx_serializer_baud_tick #(
    .Div (BaudDiv)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .load (baud_load),
    .en   (baud_en),
    .tick (baud_tick)
  );

  assign last_stop = (STOP_BITS < 2) || stop_idx_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    txd_d       = txd_q;
    ren_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    baud_load   = 1'b0;
    baud_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ena && !tx_fifo_empty) begin
          ren_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = StRd;
        end
      end
      // Read strobe is on the bus this cycle; data arrives next cycle.
      StRd: begin
        state_d = StLat;
      end
      StLat: begin
        shreg_d    = tx_fifo_rdata;
        par_d      = (^tx_fifo_rdata) ^ (PARITY_ODD != 0);
        txd_d      = 1'b0;
        bit_idx_d  = 3'd0;
        stop_idx_d = 1'b0;
        baud_load  = 1'b1;
        state_d    = StStart;
      end
      StStart: begin
        baud_en = 1'b1;
        if (baud_tick) begin
          txd_d   = shreg_q[0];
          state_d = StData;
        end
      end
      StData: begin
        baud_en = 1'b1;
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              txd_d   = par_q;
              state_d = StPar;
            end else begin
              txd_d   = 1'b1;
              state_d = StStop;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shreg_q[bit_idx_q + 3'd1];
          end
        end
      end
      StPar: begin
        baud_en = 1'b1;
        if (baud_tick) begin
          txd_d   = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        baud_en = 1'b1;
        if (baud_tick) begin
          if (last_stop) begin
            done_d      = 1'b1;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = StIdle;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      txd_q       <= 1'b1;
      ren_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      txd_q       <= txd_d;
      ren_q       <= ren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign txd         = txd_q;
  assign tx_fifo_ren = ren_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_uart0_tx_serializer.sv
// Bench for uart0_tx_serializer. Lane 0: no parity, 1 stop. Lane 1: even parity. Lane 2: odd
// parity. Lane 3: 2 stop bits. Each lane has its own FIFO model; a single monitor decodes txd
// against a queue of expected frames pushed by the stimulus.
module tb_uart0_tx_serializer;

  localparam int Div = 4;

  typedef struct {
    int          lane;
    logic [11:0] bits;  // bit i = i-th transmitted bit
    int          nclk;  // clocks of line to compare from the falling start edge
    bit          done;  // frame ends normally with a tx_done pulse
    int          gap;   // required idle-high clocks before this frame, -1 = any
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             mon_en;
  logic [3:0]       ena_v;
  logic [3:0]       empty_v;
  logic [3:0]       ren_v;
  logic [3:0]       txd_v;
  logic [3:0]       busy_v;
  logic [3:0]       done_v;
  logic [3:0][7:0]  rdata_v;
  logic [3:0][15:0] fcnt_v;

  logic [7:0] mem [4][16];
  logic [3:0] wr_ptr [4] = '{default: '0};
  logic [3:0] rd_ptr [4] = '{default: '0};
  int         ren_cnt [4] = '{default: 0};

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  uart0_tx_serializer #(
    .CLK_HZ(1_000_000), .BAUD(250_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena_v[0]), .tx_fifo_empty(empty_v[0]), .tx_fifo_ren(ren_v[0]),
    .tx_fifo_rdata(rdata_v[0]), .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]),
    .frame_cnt(fcnt_v[0])
  );

  uart0_tx_serializer #(
    .CLK_HZ(1_000_000), .BAUD(250_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_pe (
    .clk(clk), .rst(rst), .ena(ena_v[1]), .tx_fifo_empty(empty_v[1]), .tx_fifo_ren(ren_v[1]),
    .tx_fifo_rdata(rdata_v[1]), .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]),
    .frame_cnt(fcnt_v[1])
  );

  uart0_tx_serializer #(
    .CLK_HZ(1_000_000), .BAUD(250_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) dut_po (
    .clk(clk), .rst(rst), .ena(ena_v[2]), .tx_fifo_empty(empty_v[2]), .tx_fifo_ren(ren_v[2]),
    .tx_fifo_rdata(rdata_v[2]), .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]),
    .frame_cnt(fcnt_v[2])
  );

  uart0_tx_serializer #(
    .CLK_HZ(1_000_000), .BAUD(250_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut_s2 (
    .clk(clk), .rst(rst), .ena(ena_v[3]), .tx_fifo_empty(empty_v[3]), .tx_fifo_ren(ren_v[3]),
    .tx_fifo_rdata(rdata_v[3]), .txd(txd_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]),
    .frame_cnt(fcnt_v[3])
  );

  // Normal-mode FIFO models: data appears the cycle after the read strobe.
  always_comb begin
    empty_v = '0;
    for (int l = 0; l < 4; l++) empty_v[l] = (wr_ptr[l] == rd_ptr[l]);
  end

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (ren_v[l]) begin
        rdata_v[l] <= mem[l][rd_ptr[l]];
        rd_ptr[l]  <= rd_ptr[l] + 4'd1;
        ren_cnt[l] <= ren_cnt[l] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] b);
    mem[lane][wr_ptr[lane]] = b;
    wr_ptr[lane] = wr_ptr[lane] + 4'd1;
  endtask

  task automatic expect_frame(input int lane, input logic [11:0] bits, input int nclk,
                              input bit done, input int gap);
    exp_t e;
    e.lane = lane;
    e.bits = bits;
    e.nclk = nclk;
    e.done = done;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int lane);
    int n = 0;
    while ((exp_q.size() != 0 || busy_v[lane] !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("drain_timeout", 64'(n), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_low(input int lane);
    int n = 0;
    while (txd_v[lane] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("start_bit_timeout", 64'(n), 64'(0));
  endtask

  initial begin : monitor
    exp_t        e;
    int          gap;
    int          lane;
    int          plane;
    bit          pend;
    logic [63:0] got;
    logic [63:0] want;
    gap   = 0;
    pend  = 1'b0;
    plane = 0;
    wait (mon_en === 1'b1);
    forever begin
      @(negedge clk);
      if (txd_v === 4'hF) begin
        if (pend) begin
          check("done_pulse", 64'(done_v[plane]), 64'(1));
          check("busy_after_frame", 64'(busy_v[plane]), 64'(0));
          pend = 1'b0;
        end
        gap++;
      end else if (exp_q.size() == 0) begin
        check("unexpected_frame", 64'(txd_v), 64'hF);
        while (txd_v !== 4'hF) @(negedge clk);
        gap = 0;
      end else begin
        e    = exp_q.pop_front();
        lane = 0;
        for (int l = 3; l >= 0; l--) if (txd_v[l] !== 1'b1) lane = l;
        check("frame_lane", 64'(lane), 64'(e.lane));
        if (e.gap >= 0) check("frame_gap", 64'(gap), 64'(e.gap));
        check("busy_in_frame", 64'(busy_v[e.lane]), 64'(1));
        got  = '0;
        want = '0;
        for (int i = 0; i < e.nclk; i++) begin
          if (i > 0) @(negedge clk);
          got[i]  = txd_v[e.lane];
          want[i] = e.bits[i / Div];
        end
        check("frame_bits", got, want);
        pend  = e.done;
        plane = e.lane;
        gap   = 0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst    = 1'b1;
    mon_en = 1'b0;
    ena_v  = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_txd", 64'(txd_v), 64'hF);
    check("reset_ren", 64'(ren_v), 64'h0);
    check("reset_busy", 64'(busy_v), 64'h0);
    check("reset_done", 64'(done_v), 64'h0);
    check("reset_frame_cnt", 64'(fcnt_v[0]), 64'h0);
    mon_en = 1'b1;

    // T1: single byte 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    expect_frame(0, {1'b1, 8'hA5, 1'b0}, 40, 1'b1, -1);
    push(0, 8'hA5);
    wait_drain(0);
    check("t1_ren_count", 64'(ren_cnt[0]), 64'(1));
    check("t1_frame_cnt", 64'(fcnt_v[0]), 64'(1));
    check("t1_fifo_empty", 64'(empty_v[0]), 64'(1));

    // T2: burst, 3 idle clocks between back-to-back frames
    expect_frame(0, {1'b1, 8'h7F, 1'b0}, 40, 1'b1, -1);
    expect_frame(0, {1'b1, 8'hFF, 1'b0}, 40, 1'b1, 3);
    expect_frame(0, {1'b1, 8'h7F, 1'b0}, 40, 1'b1, 3);
    push(0, 8'h7F);
    push(0, 8'hFF);
    push(0, 8'h7F);
    wait_drain(0);
    check("t2_ren_count", 64'(ren_cnt[0]), 64'(4));
    check("t2_frame_cnt", 64'(fcnt_v[0]), 64'(4));

    // T3: parity bit 1 for 0x01 even and for 0x03 odd; 44-clock frames
    expect_frame(1, {1'b1, 1'b1, 8'h01, 1'b0}, 44, 1'b1, -1);
    push(1, 8'h01);
    wait_drain(1);
    check("t3_even_frame_cnt", 64'(fcnt_v[1]), 64'(1));
    check("t3_even_ren_count", 64'(ren_cnt[1]), 64'(1));
    expect_frame(2, {1'b1, 1'b1, 8'h03, 1'b0}, 44, 1'b1, -1);
    push(2, 8'h03);
    wait_drain(2);
    check("t3_odd_frame_cnt", 64'(fcnt_v[2]), 64'(1));

    // T4: ena drops 10 clocks into the 0x33 frame; 0xCC waits
    expect_frame(0, {1'b1, 8'h33, 1'b0}, 40, 1'b1, -1);
    push(0, 8'h33);
    push(0, 8'hCC);
    wait_low(0);
    repeat (9) @(negedge clk);
    ena_v[0] = 1'b0;
    wait_drain(0);
    repeat (20) @(negedge clk);
    check("t4_no_read_ren_count", 64'(ren_cnt[0]), 64'(5));
    check("t4_held_txd", 64'(txd_v[0]), 64'(1));
    check("t4_held_busy", 64'(busy_v[0]), 64'(0));
    check("t4_still_queued", 64'(empty_v[0]), 64'(0));
    check("t4_frame_cnt", 64'(fcnt_v[0]), 64'(5));
    expect_frame(0, {1'b1, 8'hCC, 1'b0}, 40, 1'b1, -1);
    ena_v[0] = 1'b1;
    wait_drain(0);
    check("t4_resume_ren_count", 64'(ren_cnt[0]), 64'(6));

    // T5: reset during D3 of 0x37 (start + D0..D2 + 2 clocks of D3), then 0xC3 sent cleanly
    expect_frame(0, {1'b1, 8'h37, 1'b0}, 18, 1'b0, -1);
    expect_frame(0, {1'b1, 8'hC3, 1'b0}, 40, 1'b1, 3);
    push(0, 8'h37);
    push(0, 8'hC3);
    wait_low(0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_reset_txd", 64'(txd_v[0]), 64'(1));
    check("t5_reset_busy", 64'(busy_v[0]), 64'(0));
    check("t5_reset_done", 64'(done_v[0]), 64'(0));
    check("t5_reset_frame_cnt", 64'(fcnt_v[0]), 64'(0));
    wait_drain(0);
    check("t5_ren_count", 64'(ren_cnt[0]), 64'(8));
    check("t5_frame_cnt", 64'(fcnt_v[0]), 64'(1));
    check("t5_fifo_empty", 64'(empty_v[0]), 64'(1));

    // T6: 2 stop bits (8 high clocks) and frame counter wrap
    force dut_s2.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_s2.frame_cnt_q;
    expect_frame(3, {2'b11, 8'h96, 1'b0}, 44, 1'b1, -1);
    push(3, 8'h96);
    wait_drain(3);
    check("t6_frame_cnt_wrap", 64'(fcnt_v[3]), 64'h0);
    check("t6_ren_count", 64'(ren_cnt[3]), 64'(1));

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
